// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Clocked controller around a small ALU function set. Operand A is always
//   acc[WIDTH-1:0]; operand B arrives with each request. Op 0 runs a
//   bit-serial ripple add (one bit per cycle), ops 1-7 finish in one execute
//   cycle.
//
//   Optional feature: define ALU_SEQ_STICKY_OVF_EN to enable the sticky
//   carry flag (ovf_sticky). When undefined, ovf_sticky is tied low.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   start      request strobe, sampled only while ready=1
//   op         operation code, sampled with start
//   b          operand B, sampled with start
//   ready      high only in IDLE
//   busy       high in EXEC and SERIAL
//   done       one-cycle pulse, acc valid in that cycle
//   acc        accumulator / result register
//   carry      carry-out of the last completed add op
//   ovf_sticky sticky carry flag
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start, ready=1
// S_EXEC   | operands latched; ops 1-7 complete here, op 0 starts serial
// S_SERIAL | one full-adder step per cycle, LSB first
// S_DONE   | result valid, done=1 for this single cycle

module alu_op_sequencer #(
  parameter int                   WIDTH    = 4,
  parameter logic [2*WIDTH-1:0]   ACC_INIT = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] acc,
  output logic               carry,
  output logic               ovf_sticky
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SERIAL, S_DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic [CW-1:0]    bit_cnt;

  logic [WIDTH:0]   add_full;
  logic             s_bit;
  logic             c_bit;
  logic [AW-1:0]    exec_res;

  // Single-cycle adder, only meaningful in EXEC (a_q/b_q shift in SERIAL).
  assign add_full = {1'b0, a_q} + {1'b0, b_q};

  // Serial full adder works on the LSBs while a_q/b_q shift right.
  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_bit = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    exec_res = acc;
    case (op_q)
      3'd1:    exec_res = AW'(add_full);
      3'd2:    exec_res = {a_q | b_q, a_q ^ b_q};
      3'd3:    exec_res = AW'(|{a_q, b_q});
      3'd4:    exec_res = AW'(&{a_q, b_q});
      3'd5:    exec_res = {a_q, b_q};
      3'd6,
      3'd7:    exec_res = ACC_INIT;
      default: exec_res = acc;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc     <= ACC_INIT;
      carry   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= acc[WIDTH-1:0];
            b_q   <= b;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          c_q     <= 1'b0;
          sum_q   <= '0;
          bit_cnt <= CW'(WIDTH - 1);
          if (op_q == 3'd0) begin
            state <= S_SERIAL;
          end else begin
            acc <= exec_res;
            if (op_q == 3'd1)
              carry <= add_full[WIDTH];
            else if (op_q == 3'd6 || op_q == 3'd7)
              carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_SERIAL: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_bit;
          sum_q <= {s_bit, sum_q[WIDTH-1:1]};
          // Terminal count: this step produces the MSB, so assemble the
          // result directly from the in-flight bit rather than sum_q.
          if (bit_cnt == '0) begin
            acc   <= AW'({c_bit, s_bit, sum_q[WIDTH-1:1]});
            carry <= c_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  // Clear has priority over set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      ovf_sticky <= 1'b0;
    else if (state == S_EXEC && (op_q == 3'd6 || op_q == 3'd7))
      ovf_sticky <= 1'b0;
    else if (state == S_EXEC && op_q == 3'd1 && add_full[WIDTH])
      ovf_sticky <= 1'b1;
    else if (state == S_SERIAL && bit_cnt == '0 && c_bit)
      ovf_sticky <= 1'b1;
  end
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int W = 4;
`ifdef ALU_SEQ_STICKY_OVF_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [2:0]   op_i;
  logic [W-1:0] b_i;
  logic         ready, busy, done, carry, ovf_sticky;
  logic [2*W-1:0] acc;

  alu_op_sequencer #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .op         (op_i),
    .b          (b_i),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .acc        (acc),
    .carry      (carry),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] acc;
    logic       carry;
    logic       sticky;
    logic [2:0] op;
    int         e0;
  } exp_t;

  exp_t q[$];

  // Reference model state
  int acc_m = 0;
  bit carry_m = 0;
  bit sticky_m = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Computes the architectural result of one op from plain arithmetic.
  task automatic push_model(input int o, input int bv);
    exp_t e;
    int a, s;
    a = acc_m % 16;
    case (o)
      0, 1: begin
        s = a + bv;
        acc_m = s;
        carry_m = (s > 15);
        if (STICKY_EN && carry_m) sticky_m = 1;
      end
      2: acc_m = (a | bv) * 16 + (a ^ bv);
      3: acc_m = (a != 0 || bv != 0) ? 1 : 0;
      4: acc_m = (a == 15 && bv == 15) ? 1 : 0;
      5: acc_m = a * 16 + bv;
      default: begin
        acc_m = 0;
        carry_m = 0;
        sticky_m = 0;
      end
    endcase
    e.acc = 8'(acc_m);
    e.carry = carry_m;
    e.sticky = sticky_m;
    e.op = 3'(o);
    e.e0 = cyc + 1;
    q.push_back(e);
  endtask

  // Monitor: pops and compares whenever the DUT signals done.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("acc", int'(acc), int'(e.acc));
        check("carry", int'(carry), int'(e.carry));
        check("ovf_sticky", int'(ovf_sticky), int'(e.sticky));
        check("latency", cyc - e.e0, (e.op == 3'd0) ? W + 1 : 1);
        check("busy_in_done", int'(busy), 0);
      end
    end
  end

  task automatic issue(input int o, input int bv);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1 (t=%0t)", $time);
      return;
    end
    start = 1'b1;
    op_i = 3'(o);
    b_i = 4'(bv);
    push_model(o, bv);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", int'(ready), 1);
  endtask

  initial begin
    int n, low_run, last_op, cur_op;
    bit saw_done;
    resetn = 1'b0;
    start = 1'b0;
    op_i = '0;
    b_i = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_acc", int'(acc), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_sticky", int'(ovf_sticky), 0);

    // Abort an add on its 2nd SERIAL cycle.
    issue(5, 3);
    issue(0, 5);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    resetn = 1'b0;
    q.delete();
    acc_m = 0;
    carry_m = 0;
    sticky_m = 0;
    saw_done = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    check("abort_acc", int'(acc), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_no_done", int'(saw_done), 0);

    // Directed sequence.
    issue(5, 4'hA);
    issue(0, 4'h7);
    issue(5, 4'hC);
    issue(2, 4'h5);
    issue(3, 4'h0);
    issue(4, 4'hF);

    // op0 / op1 equivalence sweep.
    for (int a = 0; a < 16; a++) begin
      for (int bb = 0; bb < 16; bb++) begin
        issue(5, a);
        issue(0, bb);
        issue(5, a);
        issue(1, bb);
      end
    end

    // start held high: one op per IDLE visit, ready-low length per op.
    wait_ready();
    start = 1'b1;
    low_run = 0;
    last_op = 1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (ready) begin
        if (low_run > 0)
          check("ready_low_len", low_run, (last_op == 0) ? W + 2 : 2);
        low_run = 0;
        cur_op = (i < 25) ? 1 : 0;
        op_i = 3'(cur_op);
        b_i = 4'($urandom_range(0, 15));
        push_model(cur_op, int'(b_i));
        last_op = cur_op;
      end else begin
        low_run++;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;

    // Sticky flag sequence.
    issue(6, 0);
    issue(5, 4'hF);
    issue(1, 4'h1);
    issue(5, 4'h0);
    issue(6, 0);

    // Randomized ops.
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", q.size(), 0);
    repeat (2) @(negedge clk);
    check("final_ovf_vs_model", int'(ovf_sticky), int'(sticky_m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Clocked controller wrapped around the 4-bit ALU function set: add, OR/XOR pack, reductions, pass-through.
- Holds an 8-bit accumulator; operand A is always acc[3:0], operand B is supplied per request.
- Op 0 sequences a bit-serial ripple add, one bit per cycle. Ops 1-5 finish in one execute cycle.
- A start/ready/done handshake lets a front-end (switch/key decoder or test FSM) issue ops.

Parameters:
- WIDTH, 4, operand width; accumulator is 2*WIDTH bits; serial add takes WIDTH cycles.
- ACC_INIT, 8'h00, accumulator value after reset and after a clear op.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only while ready=1.
- op  input  3  operation code; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high only in IDLE.
- busy  output  1  high in EXEC and SERIAL.
- done  output  1  one-cycle pulse in DONE; acc is valid in that cycle.
- acc  output  2*WIDTH  accumulator / result register.
- carry  output  1  carry-out of the last completed add op.
- ovf_sticky  output  1  sticky carry flag (see Optional Feature).

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, acc=ACC_INIT, carry=0, ovf_sticky=0, done=0, busy=0.
  - Internal op/A/B latches and bit counter cleared; ready=1 as soon as reset deasserts.
  - Reset mid-operation aborts the op; acc is not updated.
- FSM states:
  - IDLE -> EXEC on edge where start=1. Latch op, b, and a=acc[3:0].
  - EXEC -> SERIAL if op=0, else -> DONE. For op 1-7, acc and carry load on this edge.
  - SERIAL: one full-adder step per cycle at bit index k=0..WIDTH-1. Sum bit goes into a shift register; carry is held in a flop initialised to 0. After k=WIDTH-1: -> DONE, and acc={0..,cout,sum} loads on that edge.
  - DONE -> IDLE unconditionally; done=1 for exactly this cycle.
- Latency, counting from the start-sampling edge E0:
  - Ops 1-7: done high in the cycle after E1.
  - Op 0: done high in the cycle after E(WIDTH+1).
  - Next start is accepted at the edge that leaves DONE+1, i.e. only when ready=1.
- start while ready=0 is ignored, not queued. op/b changes during busy have no effect.
- Op results, all zero-extended to 2*WIDTH:
  - 0: serial a+b = {cout,sum}. carry=cout.
  - 1: a+b using a single-cycle adder. Result is identical to op 0. carry=cout.
  - 2: {a|b, a^b}. carry unchanged.
  - 3: reduction OR of {a,b}. carry unchanged.
  - 4: reduction AND of {a,b}. carry unchanged.
  - 5: {a,b}. carry unchanged.
  - 6, 7: acc=ACC_INIT, carry=0, ovf_sticky=0.
- Chaining: because A=acc[3:0], upper acc bits from a previous op never feed A. Example: after op5 with a=3,b=9, acc=8'h39 and the next A=9.
- Wrap-around: 4-bit sum wraps; the carry goes to acc[4] and to carry.

Optional Feature:
- Macro ALU_SEQ_STICKY_OVF_EN.
- Defined: ovf_sticky is set on any op 0/1 completion with cout=1. It stays set until reset or op 6/7. If cout=1 and a clear happen simultaneously, the clear wins (impossible in one op; documented for completeness).
- Undefined: ovf_sticky is tied 0 and no flop is inferred.

Test Plan:
- Reset mid-SERIAL: resetn low on the 2nd SERIAL cycle -> acc=8'h00, ready=1, done never pulses.
- acc=0, start op=5 b=4'hA -> done one cycle after E1, acc=8'h0A. Then op0 b=4'h7 -> serial add, done one cycle after E5, acc=8'h11, carry=1.
- acc=8'h0C, op2 b=4'h5 -> acc=8'hD9. op3 b=0 with acc[3:0]=9 -> acc=8'h01. op4 b=4'hF with a=1 -> acc=8'h00.
- Op0 vs op1 equivalence: sweep all 256 (a,b) pairs (load a via op5 b=a, then add b) -> identical acc and carry; op0 latency WIDTH+1 edges vs op1 1 edge.
- start held high through busy and DONE -> exactly one op per IDLE visit; ready low for 2 cycles (op1) and WIDTH+2 cycles (op0).
- ALU_SEQ_STICKY_OVF_EN defined: op5 b=F, op1 b=1 -> ovf_sticky=1. op5 b=0 -> still 1. op6 -> 0. Undefined: ovf_sticky stays 0 throughout.
